// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional build macro used by this block: SERIAL_SUB_OVF_EN.
package sub_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Start/done handshake bundle for serial_sub.
// SERIAL_SUB_OVF_EN adds the signed overflow flag.
interface serial_sub_if
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, ovf
    );
`else
    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout
    );
`endif

endinterface

// File: rtl/full_sub.sv
// Combinational 1-bit full subtractor cell: x - y - bi.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, one bit per clock.
// SERIAL_SUB_OVF_EN adds the signed overflow output.
module serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic       clk,
    input logic       rst_n,
    serial_sub_if.slave bus
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             diff;
    logic             bnext;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             am;
    logic             bm;
    logic             ovf_q;
`endif

    full_sub u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bi   (br),
        .diff (diff),
        .bo   (bnext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            am     <= 1'b0;
            bm     <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        br     <= bus.bin;
                        res    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        am     <= bus.a[WIDTH-1];
                        bm     <= bus.b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    res <= {diff, res[WIDTH-1:1]};
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= bnext;
                    cnt <= cnt + ONE;
                    // last cell result goes straight to the output regs
                    if (cnt == LAST) begin
                        d_q    <= {diff, res[WIDTH-1:1]};
                        bout_q <= bnext;
                        done_q <= 1'b1;
                        state  <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q  <= (am != bm) && (diff != am);
`endif
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed scoreboard bench for serial_sub (WIDTH=4).
// Define SERIAL_SUB_OVF_EN to also exercise the overflow flag.
module tb_serial_sub;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int bin);
        exp_t e;
        int   r;
        r      = a - b - bin;
        e.d    = r[W-1:0];
        e.bout = (a < b + bin);
        e.ovf  = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
        return e;
    endfunction

    // Drive one start pulse; returns at the first negedge after the accept edge.
    task automatic issue(input int a, input int b, input int bin);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a[W-1:0];
        bus.b     = b[W-1:0];
        bus.bin   = bin[0];
        q.push_back(model(a, b, bin));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int   cyc;
        int   nbusy;
        exp_t e;
        cyc   = 1;
        nbusy = bus.busy ? 1 : 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) nbusy++;
        end
        check({tag, ":latency"}, cyc, 5);
        check({tag, ":busy_cycles"}, nbusy, 5);
        if (q.size() > 0) begin
            e = q.pop_front();
            check({tag, ":d"}, bus.d, e.d);
            check({tag, ":bout"}, bus.bout, e.bout);
`ifdef SERIAL_SUB_OVF_EN
            check({tag, ":ovf"}, bus.ovf, e.ovf);
`endif
        end
        @(negedge clk);
        check({tag, ":done_drop"}, bus.done, 1'b0);
        check({tag, ":busy_drop"}, bus.busy, 1'b0);
    endtask

    task automatic run(input string tag, input int a, input int b, input int bin);
        issue(a, b, bin);
        wait_done(tag);
    endtask

    initial begin
        int   nd;
        int   nb;
        exp_t e;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst:busy", bus.busy, 1'b0);
        check("rst:done", bus.done, 1'b0);
        check("rst:d", bus.d, 4'h0);
        check("rst:bout", bus.bout, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        run("sub7_2", 7, 2, 0);
        run("sub2_7", 2, 7, 0);
        run("sub0_0_b1", 0, 0, 1);

        // Asynchronous reset two edges into SHIFT of 5-1.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd5;
        bus.b     = 4'd1;
        bus.bin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst:busy", bus.busy, 1'b0);
        check("arst:done", bus.done, 1'b0);
        check("arst:d", bus.d, 4'h0);
        check("arst:bout", bus.bout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        nb = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) nd++;
            if (bus.busy) nb++;
        end
        check("arst:stray_done", nd, 0);
        check("arst:stray_busy", nb, 0);

        run("subF_F", 15, 15, 0);

        // Starts during SHIFT and DONE must be ignored.
        issue(9, 3, 0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd1;
        bus.b     = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ign:done", bus.done, 1'b1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check("ign:d", bus.d, e.d);
            check("ign:bout", bus.bout, e.bout);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ign:done_drop", bus.done, 1'b0);
        check("ign:no_accept", bus.busy, 1'b0);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check("ign:single_done", nd, 0);
        check("ign:d_held", bus.d, 4'd6);

        run("after_ign", 1, 1, 0);
        run("subA_3_b1", 10, 3, 1);
        run("subC_5", 12, 5, 0);
`ifdef SERIAL_SUB_OVF_EN
        run("ovf8_1", 8, 1, 0);
        run("ovf3_1", 3, 1, 0);
        run("ovf7_F", 7, 15, 0);
`endif
        check("sb:empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
